mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of all ports.
REQ-002 Parameter DATA_W, default 16, data width; mask width is DATA_W/8.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a_read, b_read  input  1  requester read request.
REQ-006 a_write, b_write  input  1  requester write request.
REQ-007 a_address, b_address  input  ADDR_W  requester address.
REQ-008 a_wdata, b_wdata  input  DATA_W  requester write data.
REQ-009 a_mask, b_mask  input  DATA_W/8  requester byte mask.
REQ-010 a_resp, b_resp  output  1  one-cycle completion pulse to the requester.
REQ-011 a_rdata, b_rdata  output  DATA_W  read data to the requester.
REQ-012 mem_read, mem_write  output  1  downstream command, registered.
REQ-013 mem_address  output  ADDR_W  downstream address, registered.
REQ-014 mem_wdata  output  DATA_W  downstream write data, registered.
REQ-015 mem_mask  output  DATA_W/8  downstream byte mask, registered.
REQ-016 mem_resp  input  1  downstream completion.
REQ-017 mem_rdata  input  DATA_W  downstream read data, valid with mem_resp.

Function
REQ-018 The FSM SHALL have the states IDLE, SERVE_A and SERVE_B.
REQ-019 A requester SHALL be pending when its read or write is high; when read and write are both high, the request SHALL be treated as a write.
REQ-020 In IDLE with exactly one requester pending, the FSM SHALL enter that requester's SERVE state on the next edge.
REQ-021 In IDLE with both requesters pending, the FSM SHALL grant the requester not recorded in last_grant, then update last_grant to the winner (round-robin).
REQ-022 On the grant edge, the FSM SHALL register the winner's op, address, wdata and mask onto the mem_* outputs, so mem_read or mem_write is high from the cycle after the request is first seen in IDLE (latency 1).
REQ-023 In SERVE_x, the mem_* outputs SHALL be held stable regardless of changes on the requester inputs.
REQ-024 In SERVE_x, x_resp SHALL equal mem_resp combinationally, and the other requester's resp SHALL stay 0.
REQ-025 a_rdata and b_rdata SHALL both equal mem_rdata at all times.
REQ-026 On the edge where mem_resp is high in SERVE_x, the FSM SHALL return to IDLE and clear mem_read and mem_write; each transaction therefore costs at least one IDLE turnaround cycle.
REQ-027 mem_resp high while in IDLE SHALL be ignored, with no resp forwarded.
REQ-028 A requester that drops its request before its resp SHALL NOT abort the transaction; the arbiter SHALL still complete it and pulse resp.
REQ-029 A requester re-requesting in the cycle after its resp SHALL be arbitrated normally; with the other requester pending, the other SHALL win.

Reset
REQ-030 While rst_n is low, state SHALL be IDLE, last_grant SHALL be B, and mem_read, mem_write, mem_address, mem_wdata, mem_mask, a_resp and b_resp SHALL all be 0.
REQ-031 Assertion of rst_n mid-transaction SHALL immediately deassert mem_read and mem_write, and no resp SHALL be forwarded for the aborted transaction.
REQ-032 After reset, the first tie SHALL be won by A.

Structure
REQ-033 The package mem_arb_pkg SHALL hold the state enum (IDLE, SERVE_A, SERVE_B), the grant enum (GRANT_A, GRANT_B) and the default width constants.
REQ-034 mem_arbiter SHALL be a single module with no sub-module; the round-robin state SHALL be the one-bit register last_grant.

Verification
REQ-035 Scenario 1: a_read, address 0x0040, with no B request -> mem_read high one cycle later with mem_address=0x0040; mem_resp with rdata 0xBEEF -> a_resp pulses 1 cycle with a_rdata=0xBEEF, and b_resp stays 0.
REQ-036 Scenario 2: simultaneous a_read 0x0010 and b_write 0x0020/0x1234 mask 2'b01 after reset -> A is served first, then after 1 IDLE cycle B is served with mem_wdata=0x1234 and mem_mask=2'b01.
REQ-037 Scenario 3: both requesters held continuously for 6 transactions -> grants alternate A, B, A, B, A, B.
REQ-038 Scenario 4: during SERVE_B, change b_address from 0x0100 to 0x0200 and drop b_write -> mem_address stays 0x0100, mem_write stays high until mem_resp, and b_resp still pulses.
REQ-039 Scenario 5: pull rst_n low while mem_read is high in SERVE_A, with mem_resp asserted in the same cycle -> mem_read is 0 within the same cycle, a_resp stays 0, and the FSM is in IDLE after release.
REQ-040 Scenario 6: a_read and a_write both high to 0x0030 -> mem_write high and mem_read low.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B
  } state_t;

  typedef enum logic {
    GRANT_A,
    GRANT_B
  } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two requesters onto one memory port; command registered 1 cycle after request.
// Requesters stall until their one-cycle resp; one transaction in flight, IDLE turnaround between grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_mask,
  output logic                a_resp,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] b_mask,
  output logic                b_resp,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t                state_q, state_d;
  grant_t                last_grant_q, last_grant_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]     mem_address_q, mem_address_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0]   mem_mask_q, mem_mask_d;

  logic a_pend, b_pend;
  assign a_pend = a_read | a_write;
  assign b_pend = b_read | b_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_B;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_mask_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_mask_q    <= mem_mask_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_mask_d    = mem_mask_q;
    case (state_q)
      IDLE: begin
        // A wins when alone or when B held the previous grant; a write dominates a read
        if (a_pend && (!b_pend || last_grant_q == GRANT_B)) begin
          state_d       = SERVE_A;
          last_grant_d  = GRANT_A;
          mem_write_d   = a_write;
          mem_read_d    = a_read & ~a_write;
          mem_address_d = a_address;
          mem_wdata_d   = a_wdata;
          mem_mask_d    = a_mask;
        end else if (b_pend) begin
          state_d       = SERVE_B;
          last_grant_d  = GRANT_B;
          mem_write_d   = b_write;
          mem_read_d    = b_read & ~b_write;
          mem_address_d = b_address;
          mem_wdata_d   = b_wdata;
          mem_mask_d    = b_mask;
        end
      end
      SERVE_A, SERVE_B: begin
        if (mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  assign a_resp      = (state_q == SERVE_A) & mem_resp;
  assign b_resp      = (state_q == SERVE_B) & mem_resp;
  assign a_rdata     = mem_rdata;
  assign b_rdata     = mem_rdata;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_mask    = mem_mask_q;

endmodule
